msix_interrupt_sender: RTL and testbench

- Downstream delivery stage for the MSI-X table block. Accepts one pending vector request (msix_interrupt/msix_vector) at a time and fetches that vector's address, data and mask from the table.
- Drives the PCIe core's MSI-X message interface (cfg_interrupt_msix_*) and handles sent/fail/timeout with bounded retry.
- Returns a one-cycle acknowledge upstream; re-pends vectors that are masked, or that could not be delivered, through a PBA set strobe.

---
 rtl/msix_interrupt_sender_if.sv | 44 ++++
 rtl/msix_interrupt_sender.sv | 171 +++++++++++++++++
 tb/tb_msix_interrupt_sender.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msix_interrupt_sender_if.sv
// Bundle of the upstream request, table lookup and PCIe core MSI-X message signals.
// master = sender side, slave = table block / core / capability side.
interface msix_interrupt_sender_if #(
  parameter int VEC_W = 11
) ();
  logic             msix_enable;
  logic             msix_function_mask;
  logic             msix_interrupt;
  logic [VEC_W-1:0] msix_vector;
  logic             msix_interrupt_ack;
  logic             tbl_rd_en;
  logic [VEC_W-1:0] tbl_rd_vector;
  logic             tbl_rd_valid;
  logic [63:0]      tbl_msg_addr;
  logic [31:0]      tbl_msg_data;
  logic             tbl_masked;
  logic             cfg_interrupt_msix_int;
  logic [63:0]      cfg_interrupt_msix_address;
  logic [31:0]      cfg_interrupt_msix_data;
  logic             cfg_interrupt_msix_sent;
  logic             cfg_interrupt_msix_fail;
  logic             pba_set;
  logic [VEC_W-1:0] pba_vector;
  logic             err_drop;
  logic [15:0]      sent_count;

  modport master (
    input  msix_enable, msix_function_mask, msix_interrupt, msix_vector,
    input  tbl_rd_valid, tbl_msg_addr, tbl_msg_data, tbl_masked,
    input  cfg_interrupt_msix_sent, cfg_interrupt_msix_fail,
    output msix_interrupt_ack, tbl_rd_en, tbl_rd_vector,
    output cfg_interrupt_msix_int, cfg_interrupt_msix_address, cfg_interrupt_msix_data,
    output pba_set, pba_vector, err_drop, sent_count
  );

  modport slave (
    output msix_enable, msix_function_mask, msix_interrupt, msix_vector,
    output tbl_rd_valid, tbl_msg_addr, tbl_msg_data, tbl_masked,
    output cfg_interrupt_msix_sent, cfg_interrupt_msix_fail,
    input  msix_interrupt_ack, tbl_rd_en, tbl_rd_vector,
    input  cfg_interrupt_msix_int, cfg_interrupt_msix_address, cfg_interrupt_msix_data,
    input  pba_set, pba_vector, err_drop, sent_count
  );
endinterface

// File: rtl/msix_interrupt_sender.sv
// MSI-X delivery stage: looks up a pending vector's table entry, sends it to the
// PCIe core with bounded retry, and re-pends the vector when it cannot be delivered.
module msix_interrupt_sender #(
  parameter int VEC_W          = 11,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int BACKOFF_CYCLES = 16
) (
  input logic                     clk,
  input logic                     rst,
  msix_interrupt_sender_if.master bus
);
  // state     | meaning
  // IDLE      | waiting for an enabled, unmasked request
  // FETCH     | one-cycle table lookup strobe
  // WAIT_TBL  | waiting for the table entry
  // SEND      | one-cycle message strobe to the core
  // WAIT_CORE | core owns the message; wait for sent/fail/timeout
  // BACKOFF   | idle gap before the next attempt
  // DONE      | acknowledge upstream

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_TBL, S_SEND, S_WAIT_CORE, S_BACKOFF, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [63:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             pba_q, pba_d;
  logic             drop_q, drop_d;
  logic             rd_en, msg_int, en_ok, retry_left;

  assign en_ok      = bus.msix_enable & ~bus.msix_function_mask;
  assign retry_left = (retry_q < RTY_W'(MAX_RETRY));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    data_d  = data_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    pba_d   = 1'b0;
    drop_d  = 1'b0;
    rd_en   = 1'b0;
    msg_int = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.msix_interrupt && en_ok) begin
          vec_d   = bus.msix_vector;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!en_ok) begin
          pba_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          rd_en   = 1'b1;
          state_d = S_WAIT_TBL;
        end
      end
      S_WAIT_TBL: begin
        if (bus.tbl_rd_valid) begin
          addr_d = bus.tbl_msg_addr;
          data_d = bus.tbl_msg_data;
          if (!en_ok || bus.tbl_masked) begin
            pba_d   = 1'b1;
            state_d = S_DONE;
          end else if (bus.tbl_msg_addr[1:0] != 2'b00) begin
            pba_d   = 1'b1;
            drop_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            retry_d = '0;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!en_ok) begin
          pba_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          msg_int = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT_CORE;
        end
      end
      S_WAIT_CORE: begin
        // sent takes priority over a simultaneous fail
        if (bus.cfg_interrupt_msix_sent) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_DONE;
        end else if (bus.cfg_interrupt_msix_fail || tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          if (retry_left && en_ok) begin
            retry_d = retry_q + 1'b1;
            bo_d    = BO_W'(BACKOFF_CYCLES - 1);
            state_d = S_BACKOFF;
          end else begin
            pba_d   = 1'b1;
            drop_d  = ~retry_left;
            state_d = S_DONE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_BACKOFF: begin
        if (!en_ok) begin
          pba_d   = 1'b1;
          state_d = S_DONE;
        end else if (bo_q == '0) begin
          state_d = S_SEND;
        end else begin
          bo_d = bo_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      bo_q    <= '0;
      cnt_q   <= '0;
      pba_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
      pba_q   <= pba_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.msix_interrupt_ack         = (state_q == S_DONE);
  assign bus.tbl_rd_en                  = rd_en;
  assign bus.tbl_rd_vector              = vec_q;
  assign bus.cfg_interrupt_msix_int     = msg_int;
  assign bus.cfg_interrupt_msix_address = addr_q;
  assign bus.cfg_interrupt_msix_data    = data_q;
  assign bus.pba_set                    = pba_q;
  assign bus.pba_vector                 = vec_q;
  assign bus.err_drop                   = drop_q;
  assign bus.sent_count                 = cnt_q;
endmodule

// File: tb/tb_msix_interrupt_sender.sv
// Scoreboard bench for msix_interrupt_sender: directed requests, a table model and a
// scripted core model; a monitor pops expected events as the DUT produces them.
module tb_msix_interrupt_sender;
  localparam int VEC_W = 11;

  typedef enum int {EV_RD, EV_INT, EV_DROP, EV_PBA, EV_ACK} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [63:0] a;
    logic [31:0] b;
  } ev_t;
  typedef struct {
    int kind;  // 0 none, 1 sent, 2 fail, 3 sent+fail
    int dly;
  } core_rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msix_interrupt_sender_if #(.VEC_W(VEC_W)) bif ();

  msix_interrupt_sender #(
    .VEC_W(VEC_W), .MAX_RETRY(3), .TIMEOUT_CYCLES(256), .BACKOFF_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        ack_cnt = 0;
  ev_t       exp_q[$];
  int        int_times[$];
  core_rsp_t core_q[$];

  logic [63:0] ent_addr;
  logic [31:0] ent_data;
  logic        ent_mask;
  int          ent_lat;

  task automatic chk_ev(input ev_kind_e k, input logic [63:0] a, input logic [31:0] b,
                        input string nm);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event kind=%0d a=%h b=%h, required none", nm, k, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                 nm, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bif.tbl_rd_en === 1'b1) chk_ev(EV_RD, 64'(bif.tbl_rd_vector), 32'd0, "rd");
      if (bif.cfg_interrupt_msix_int === 1'b1) begin
        chk_ev(EV_INT, bif.cfg_interrupt_msix_address, bif.cfg_interrupt_msix_data, "int");
        int_times.push_back(cyc);
      end
      if (bif.err_drop === 1'b1) chk_ev(EV_DROP, 64'd0, 32'd0, "drop");
      if (bif.pba_set === 1'b1) chk_ev(EV_PBA, 64'(bif.pba_vector), 32'd0, "pba");
      if (bif.msix_interrupt_ack === 1'b1) begin
        chk_ev(EV_ACK, 64'd0, 32'(bif.sent_count), "ack");
        ack_cnt++;
      end
    end
  end

  // Table model
  initial begin
    bif.tbl_rd_valid = 1'b0;
    bif.tbl_msg_addr = '0;
    bif.tbl_msg_data = '0;
    bif.tbl_masked   = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.tbl_rd_en === 1'b1) begin
        repeat (ent_lat) @(posedge clk);
        #1;
        bif.tbl_rd_valid = 1'b1;
        bif.tbl_msg_addr = ent_addr;
        bif.tbl_msg_data = ent_data;
        bif.tbl_masked   = ent_mask;
        @(posedge clk);
        #1;
        bif.tbl_rd_valid = 1'b0;
      end
    end
  end

  // Core model
  initial begin
    core_rsp_t r;
    bif.cfg_interrupt_msix_sent = 1'b0;
    bif.cfg_interrupt_msix_fail = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.cfg_interrupt_msix_int === 1'b1) begin
        r.kind = 0;
        r.dly  = 1;
        if (core_q.size() > 0) r = core_q.pop_front();
        if (r.kind != 0) begin
          repeat (r.dly) @(posedge clk);
          #1;
          bif.cfg_interrupt_msix_sent = (r.kind == 1 || r.kind == 3);
          bif.cfg_interrupt_msix_fail = (r.kind == 2 || r.kind == 3);
          @(posedge clk);
          #1;
          bif.cfg_interrupt_msix_sent = 1'b0;
          bif.cfg_interrupt_msix_fail = 1'b0;
        end
      end
    end
  end

  task automatic push_ev(input ev_kind_e k, input logic [63:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic push_core(input int kind, input int dly);
    core_rsp_t r;
    r.kind = kind;
    r.dly  = dly;
    core_q.push_back(r);
  endtask

  task automatic set_entry(input logic [63:0] a, input logic [31:0] d, input logic m,
                           input int lat);
    ent_addr = a;
    ent_data = d;
    ent_mask = m;
    ent_lat  = lat;
  endtask

  task automatic raise_req(input int v);
    @(posedge clk);
    #1;
    bif.msix_interrupt = 1'b1;
    bif.msix_vector    = VEC_W'(v);
  endtask

  task automatic wait_ack(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bif.msix_interrupt_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got no ack within 3000 cycles, required ack", nm);
    end
    @(posedge clk);
    #1;
    bif.msix_interrupt = 1'b0;
  endtask

  task automatic wait_int(input int base, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int_times.size() > base) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got no int within 200 cycles, required int", nm);
    end
  endtask

  task automatic expect_drained(input string nm);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d expected events still pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_int(input string nm, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  initial begin
    int base;
    rst                    = 1'b1;
    bif.msix_enable        = 1'b1;
    bif.msix_function_mask = 1'b0;
    bif.msix_interrupt     = 1'b0;
    bif.msix_vector        = '0;
    set_entry(64'd0, 32'd0, 1'b0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bif.tbl_rd_en, bif.cfg_interrupt_msix_int, bif.msix_interrupt_ack, bif.pba_set,
         bif.err_drop} !== 5'b0 || bif.sent_count !== 16'd0 ||
        bif.cfg_interrupt_msix_address !== 64'd0 || bif.cfg_interrupt_msix_data !== 32'd0 ||
        bif.pba_vector !== '0 || bif.tbl_rd_vector !== '0) begin
      n_fail++;
      $display("FAIL reset: got outputs nonzero (cnt=%h addr=%h data=%h), required all 0",
               bif.sent_count, bif.cfg_interrupt_msix_address, bif.cfg_interrupt_msix_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain delivery
    set_entry(64'hFEE0_0000, 32'h1234_5678, 1'b0, 2);
    push_core(1, 3);
    push_ev(EV_RD, 64'd5, 32'd0);
    push_ev(EV_INT, 64'hFEE0_0000, 32'h1234_5678);
    push_ev(EV_ACK, 64'd0, 32'd1);
    raise_req(5);
    wait_ack("t1_ack");
    expect_drained("t1_drained");

    // Masked entry
    set_entry(64'hFEE0_0700, 32'h0000_0007, 1'b1, 1);
    push_ev(EV_RD, 64'd7, 32'd0);
    push_ev(EV_PBA, 64'd7, 32'd0);
    push_ev(EV_ACK, 64'd0, 32'd1);
    raise_req(7);
    wait_ack("t2_ack");
    expect_drained("t2_drained");

    // Fail then sent: second strobe after fail cycle + 16 backoff cycles + SEND
    set_entry(64'hFEE0_1000, 32'hA5A5_0001, 1'b0, 1);
    push_core(2, 2);
    push_core(1, 1);
    push_ev(EV_RD, 64'd9, 32'd0);
    push_ev(EV_INT, 64'hFEE0_1000, 32'hA5A5_0001);
    push_ev(EV_INT, 64'hFEE0_1000, 32'hA5A5_0001);
    push_ev(EV_ACK, 64'd0, 32'd2);
    base = int_times.size();
    raise_req(9);
    wait_ack("t3_ack");
    expect_drained("t3_drained");
    check_int("t3_int_count", int_times.size() - base, 2);
    if (int_times.size() - base == 2)
      check_int("t3_int_gap", int_times[base+1] - int_times[base], 2 + 1 + 16);

    // Core silent: 4 attempts, 256 wait + 16 backoff + SEND between strobes, then drop
    set_entry(64'hFEE0_0010, 32'hDEAD_0003, 1'b0, 1);
    push_ev(EV_RD, 64'd3, 32'd0);
    for (int i = 0; i < 4; i++) push_ev(EV_INT, 64'hFEE0_0010, 32'hDEAD_0003);
    push_ev(EV_DROP, 64'd0, 32'd0);
    push_ev(EV_PBA, 64'd3, 32'd0);
    push_ev(EV_ACK, 64'd0, 32'd2);
    base = int_times.size();
    raise_req(3);
    wait_ack("t4_ack");
    expect_drained("t4_drained");
    check_int("t4_int_count", int_times.size() - base, 4);
    if (int_times.size() - base == 4)
      for (int i = 1; i < 4; i++)
        check_int("t4_int_gap", int_times[base+i] - int_times[base+i-1], 256 + 16 + 1);

    // Function mask holds the request off
    set_entry(64'hFEE0_0020, 32'h0000_0B0B, 1'b0, 1);
    bif.msix_function_mask = 1'b1;
    base = ack_cnt;
    raise_req(11);
    repeat (20) @(posedge clk);
    check_int("t5_masked_no_ack", ack_cnt - base, 0);
    push_core(1, 1);
    push_ev(EV_RD, 64'd11, 32'd0);
    push_ev(EV_INT, 64'hFEE0_0020, 32'h0000_0B0B);
    push_ev(EV_ACK, 64'd0, 32'd3);
    #1;
    bif.msix_function_mask = 1'b0;
    wait_ack("t5_ack");
    expect_drained("t5_drained");

    // Enable dropped during backoff
    set_entry(64'hFEE0_0D00, 32'h0000_000D, 1'b0, 1);
    push_core(2, 1);
    push_ev(EV_RD, 64'd13, 32'd0);
    push_ev(EV_INT, 64'hFEE0_0D00, 32'h0000_000D);
    push_ev(EV_PBA, 64'd13, 32'd0);
    push_ev(EV_ACK, 64'd0, 32'd3);
    base = int_times.size();
    raise_req(13);
    wait_int(base, "t6_int");
    repeat (6) @(posedge clk);
    #1;
    bif.msix_enable = 1'b0;
    wait_ack("t6_ack");
    expect_drained("t6_drained");
    check_int("t6_int_count", int_times.size() - base, 1);
    bif.msix_enable = 1'b1;

    // Misaligned address
    set_entry(64'hFEE0_0002, 32'h0000_0002, 1'b0, 3);
    push_ev(EV_RD, 64'd2, 32'd0);
    push_ev(EV_DROP, 64'd0, 32'd0);
    push_ev(EV_PBA, 64'd2, 32'd0);
    push_ev(EV_ACK, 64'd0, 32'd3);
    raise_req(2);
    wait_ack("t7_ack");
    expect_drained("t7_drained");

    // sent and fail together: sent wins
    set_entry(64'hFEE0_0080, 32'h0000_0088, 1'b0, 1);
    push_core(3, 2);
    push_ev(EV_RD, 64'd8, 32'd0);
    push_ev(EV_INT, 64'hFEE0_0080, 32'h0000_0088);
    push_ev(EV_ACK, 64'd0, 32'd4);
    raise_req(8);
    wait_ack("t8_ack");
    expect_drained("t8_drained");

    // Reset while the core owns the message; request stays held and is redelivered
    set_entry(64'hFEE0_0040, 32'h0000_0044, 1'b0, 1);
    push_ev(EV_RD, 64'd4, 32'd0);
    push_ev(EV_INT, 64'hFEE0_0040, 32'h0000_0044);
    base = int_times.size();
    raise_req(4);
    wait_int(base, "t9_int");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("t9_cnt_after_reset", int'(bif.sent_count), 0);
    expect_drained("t9_pre_drained");
    push_core(1, 1);
    push_ev(EV_RD, 64'd4, 32'd0);
    push_ev(EV_INT, 64'hFEE0_0040, 32'h0000_0044);
    push_ev(EV_ACK, 64'd0, 32'd1);
    wait_ack("t9_ack");
    expect_drained("t9_drained");

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
